// File: rtl/thor_pkg.sv
// thor_pkg: shared register-file constants and the r0 address test
package thor_pkg;
  localparam int WID = 64;
  localparam int REG_AW = 8;
  function automatic logic is_r0(input logic [REG_AW-1:0] a);
    return a[5:0] == 6'd0;
  endfunction
endpackage

// File: rtl/thor_regfile_wb_if.sv
// thor_regfile_wb_if: result push, queue control and register-file write bundle
interface thor_regfile_wb_if #(
  parameter int WID = thor_pkg::WID,
  parameter int DEPTH = 8
);
  import thor_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic flush;
  logic stall;
  logic in0_v;
  logic in1_v;
  logic [REG_AW-1:0] in0_a;
  logic [REG_AW-1:0] in1_a;
  logic [WID-1:0] in0_d;
  logic [WID-1:0] in1_d;
  logic in_rdy;
  logic wr0;
  logic wr1;
  logic [REG_AW-1:0] wa0;
  logic [REG_AW-1:0] wa1;
  logic [WID-1:0] i0;
  logic [WID-1:0] i1;
  logic [CW-1:0] count;
  modport master (
    output flush, stall, in0_v, in1_v, in0_a, in1_a, in0_d, in1_d,
    input in_rdy, wr0, wr1, wa0, wa1, i0, i1, count
  );
  modport slave (
    input flush, stall, in0_v, in1_v, in0_a, in1_a, in0_d, in1_d,
    output in_rdy, wr0, wr1, wa0, wa1, i0, i1, count
  );
endinterface

// File: rtl/thor_wb_fifo.sv
// thor_wb_fifo: 2-push/2-pop circular queue of (address, data) results
module thor_wb_fifo
  import thor_pkg::*;
#(
  parameter int WID = thor_pkg::WID,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic stall,
  input  logic in0_v,
  input  logic in1_v,
  input  logic [REG_AW-1:0] in0_a,
  input  logic [REG_AW-1:0] in1_a,
  input  logic [WID-1:0] in0_d,
  input  logic [WID-1:0] in1_d,
  output logic in_rdy,
  output logic [1:0] npop,
  output logic [REG_AW-1:0] h0_a,
  output logic [REG_AW-1:0] h1_a,
  output logic [WID-1:0] h0_d,
  output logic [WID-1:0] h1_d,
  output logic [CW-1:0] count
);
  logic [REG_AW-1:0] mem_a [DEPTH];
  logic [WID-1:0] mem_d [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [1:0] npush;
  logic [REG_AW-1:0] e0_a;
  logic [WID-1:0] e0_d;
  assign in_rdy = (CW'(DEPTH) - count) >= CW'(2);
  assign npush = in_rdy ? {1'b0, in0_v} + {1'b0, in1_v} : 2'd0;
  assign npop = stall ? 2'd0 : (count >= CW'(2) ? 2'd2 : count[1:0]);
  assign e0_a = in0_v ? in0_a : in1_a;
  assign e0_d = in0_v ? in0_d : in1_d;
  assign h0_a = mem_a[rptr];
  assign h0_d = mem_d[rptr];
  assign h1_a = mem_a[rptr + PW'(1)];
  assign h1_d = mem_d[rptr + PW'(1)];
  // entry storage; a lone in1 takes the in0 slot
  always_ff @(posedge clk) begin
    if (rst_n && !flush && npush != 2'd0) begin
      mem_a[wptr] <= e0_a;
      mem_d[wptr] <= e0_d;
    end
    if (rst_n && !flush && npush == 2'd2) begin
      mem_a[wptr + PW'(1)] <= in1_a;
      mem_d[wptr + PW'(1)] <= in1_d;
    end
  end
  // occupancy and pointers; pop uses registered count so fresh pushes wait an edge
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      count <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      count <= count + CW'(npush) - CW'(npop);
      wptr <= wptr + PW'(npush);
      rptr <= rptr + PW'(npop);
    end
  end
endmodule

// File: rtl/thor_regfile_wb.sv
// thor_regfile_wb: queues completed results and drains them as dual register-file writes
module thor_regfile_wb
  import thor_pkg::*;
#(
  parameter int WID = thor_pkg::WID,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  thor_regfile_wb_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [1:0] npop;
  logic [REG_AW-1:0] h0_a;
  logic [REG_AW-1:0] h1_a;
  logic [WID-1:0] h0_d;
  logic [WID-1:0] h1_d;
  logic in_rdy;
  logic [CW-1:0] count;
  thor_wb_fifo #(.WID(WID), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(bus.flush), .stall(bus.stall),
    .in0_v(bus.in0_v), .in1_v(bus.in1_v), .in0_a(bus.in0_a), .in1_a(bus.in1_a),
    .in0_d(bus.in0_d), .in1_d(bus.in1_d), .in_rdy(in_rdy), .npop(npop),
    .h0_a(h0_a), .h1_a(h1_a), .h0_d(h0_d), .h1_d(h1_d), .count(count)
  );
  assign bus.in_rdy = in_rdy;
  assign bus.count = count;
  // register popped entries; r0 writes are suppressed, same-address pairs both write so port 1 wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wr0 <= 1'b0;
      bus.wr1 <= 1'b0;
      bus.wa0 <= '0;
      bus.wa1 <= '0;
      bus.i0 <= '0;
      bus.i1 <= '0;
    end else if (bus.flush) begin
      bus.wr0 <= 1'b0;
      bus.wr1 <= 1'b0;
    end else begin
      bus.wr0 <= npop != 2'd0 && !is_r0(h0_a);
      bus.wr1 <= npop == 2'd2 && !is_r0(h1_a);
      if (npop != 2'd0) begin
        bus.wa0 <= h0_a;
        bus.i0 <= h0_d;
      end
      if (npop == 2'd2) begin
        bus.wa1 <= h1_a;
        bus.i1 <= h1_d;
      end
    end
  end
endmodule

// File: tb/tb_thor_regfile_wb.sv
// tb_thor_regfile_wb: directed scenarios plus random traffic against a queue model
module tb_thor_regfile_wb;
  localparam int W = 64;
  localparam int D = 8;
  typedef struct packed {
    logic [7:0] a;
    logic [63:0] d;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n;
  int vecs = 0;
  int errs = 0;
  ent_t q[$];
  logic e_wr0, e_wr1, e_v0, e_v1;
  logic [7:0] e_wa0, e_wa1;
  logic [63:0] e_i0, e_i1;
  always #5 clk = ~clk;
  thor_regfile_wb_if #(.WID(W), .DEPTH(D)) bus ();
  thor_regfile_wb #(.WID(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3) * 64) : 8'($urandom_range(1, 12));
  endfunction

  task automatic cyc(input logic r, input logic f, input logic s,
                     input logic v0, input logic [7:0] a0, input logic [63:0] d0,
                     input logic v1, input logic [7:0] a1, input logic [63:0] d1);
    ent_t ent;
    int n;
    bit rdy;
    rst_n = r;
    bus.flush = f;
    bus.stall = s;
    bus.in0_v = v0;
    bus.in0_a = a0;
    bus.in0_d = d0;
    bus.in1_v = v1;
    bus.in1_a = a1;
    bus.in1_d = d1;
    @(posedge clk);
    e_v0 = 1'b0;
    e_v1 = 1'b0;
    if (!r) begin
      q.delete();
      {e_wr0, e_wr1, e_wa0, e_wa1, e_i0, e_i1} = '0;
      e_v0 = 1'b1;
      e_v1 = 1'b1;
    end else if (f) begin
      q.delete();
      e_wr0 = 1'b0;
      e_wr1 = 1'b0;
    end else begin
      rdy = (D - q.size()) >= 2;
      n = s ? 0 : (q.size() < 2 ? q.size() : 2);
      e_wr0 = 1'b0;
      e_wr1 = 1'b0;
      if (n >= 1) begin
        ent = q.pop_front();
        e_wa0 = ent.a;
        e_i0 = ent.d;
        e_wr0 = (ent.a % 64) != 0;
        e_v0 = 1'b1;
      end
      if (n == 2) begin
        ent = q.pop_front();
        e_wa1 = ent.a;
        e_i1 = ent.d;
        e_wr1 = (ent.a % 64) != 0;
        e_v1 = 1'b1;
      end
      if (rdy && v0) q.push_back({a0, d0});
      if (rdy && v1) q.push_back({a1, d1});
    end
    @(negedge clk);
    chk("wr0", 64'(bus.wr0), 64'(e_wr0));
    chk("wr1", 64'(bus.wr1), 64'(e_wr1));
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("in_rdy", 64'(bus.in_rdy), 64'((D - q.size()) >= 2));
    if (e_v0) begin
      chk("wa0", 64'(bus.wa0), 64'(e_wa0));
      chk("i0", bus.i0, e_i0);
    end
    if (e_v1) begin
      chk("wa1", 64'(bus.wa1), 64'(e_wa1));
      chk("i1", bus.i1, e_i1);
    end
  endtask

  task automatic idle(input logic s);
    cyc(1'b1, 1'b0, s, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0);
  endtask

  task automatic pair(input logic f, input logic s);
    cyc(1'b1, f, s, 1'b1, raddr(), {$urandom, $urandom}, 1'b1, raddr(), {$urandom, $urandom});
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0);
    chk("rst_rdy", 64'(bus.in_rdy), 64'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 64'h11, 1'b0, 8'd0, 64'd0);
    chk("s1_wr0_early", 64'(bus.wr0), 64'd0);
    idle(1'b0);
    chk("s1_wr0", 64'(bus.wr0), 64'd1);
    chk("s1_wa0", 64'(bus.wa0), 64'd5);
    chk("s1_i0", bus.i0, 64'h11);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 64'hAAAA, 1'b1, 8'd7, 64'hBBBB);
    idle(1'b0);
    chk("s2_wr", {62'd0, bus.wr0, bus.wr1}, 64'd3);
    chk("s2_i1", bus.i1, 64'hBBBB);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 64'd1, 1'b1, 8'd3, 64'd2);
    idle(1'b0);
    chk("s3_wr", {62'd0, bus.wr0, bus.wr1}, 64'd1);
    chk("s3_wa1", 64'(bus.wa1), 64'd3);
    chk("s3_count", 64'(bus.count), 64'd0);
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b1);
    pair(1'b0, 1'b1);
    chk("s4_full", 64'(bus.count), 64'd8);
    chk("s4_rdy", 64'(bus.in_rdy), 64'd0);
    for (int k = 0; k < 5; k++) idle(1'b0);
    pair(1'b0, 1'b1);
    pair(1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'd9, 64'h99, 1'b0, 8'd0, 64'd0);
    chk("s5_count5", 64'(bus.count), 64'd5);
    pair(1'b1, 1'b1);
    chk("s5_flush", 64'(bus.count), 64'd0);
    idle(1'b0);
    idle(1'b0);
    for (int k = 0; k < 4; k++) pair(1'b0, 1'b1);
    idle(1'b0);
    chk("s6_count6", 64'(bus.count), 64'd6);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 64'd0, 1'b0, 8'd0, 64'd0);
    chk("s6_wr", {62'd0, bus.wr0, bus.wr1}, 64'd0);
    chk("s6_rdy", 64'(bus.in_rdy), 64'd1);
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
          1'($urandom), raddr(), {$urandom, $urandom}, 1'($urandom), raddr(), {$urandom, $urandom});
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
